pipe_cla_adder: RTL and testbench

PIPE_CLA_ADDER -- requirements
Module: pipe_cla_adder

---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_group.sv | 33 +++
 rtl/pipe_cla_adder.sv | 160 ++++++++++++++++
 tb/tb_pipe_cla_adder.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared operation type, default sizing and carry helper for the pipelined
// carry-lookahead adder.
package cla_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_t;

   localparam int CLA_WIDTH = 32;
   localparam int CLA_BLOCK = 8;

   function automatic logic carry_step(input logic g, input logic p, input logic c);
      return g | (p & c);
   endfunction

endpackage

// File: rtl/cla_group.sv
// One lookahead group: bitwise generate/propagate, in-group carries seeded by
// c_i, the BLOCK-bit sum slice and the group carry-out.
module cla_group
   import cla_pkg::*;
#(
   parameter int BLOCK = CLA_BLOCK
)
(
   input  logic [BLOCK-1:0] a_i,
   input  logic [BLOCK-1:0] b_i,
   input  logic             c_i,
   output logic [BLOCK-1:0] sum_o,
   output logic             cout_o
);

   logic [BLOCK-1:0] g_s;
   logic [BLOCK-1:0] p_s;
   logic [BLOCK:0]   c_s;

   // Generate/propagate, carry chain and sum slice for this group.
   always_comb begin
      g_s    = a_i & b_i;
      p_s    = a_i ^ b_i;
      c_s    = {(BLOCK+1){1'b0}};
      c_s[0] = c_i;
      for (int i = 0; i < BLOCK; i++) begin
         c_s[i+1] = carry_step(g_s[i], p_s[i], c_s[i]);
      end
      sum_o  = p_s ^ c_s[BLOCK-1:0];
      cout_o = c_s[BLOCK];
   end

endmodule

// File: rtl/pipe_cla_adder.sv
// WIDTH/BLOCK-stage pipelined carry-lookahead adder/subtractor with a global
// valid/ready stall. Define CLA_OVERFLOW_EN to add the registered ovf output.
module pipe_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int BLOCK = CLA_BLOCK
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  op_t              op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
`ifdef CLA_OVERFLOW_EN
   output logic             ovf,
`endif
   output logic             cout
);

   localparam int S = WIDTH / BLOCK;

   generate
      if ((BLOCK < 1) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
         $error("pipe_cla_adder: WIDTH must be a positive multiple of BLOCK");
      end
   endgenerate

   // Bank k holds the beat about to be processed by group k; operands already
   // carry the SUB inversion and the sum slices below k are complete.
   logic             vld_q  [S];
   logic             vld_d  [S];
   logic [WIDTH-1:0] opa_q  [S];
   logic [WIDTH-1:0] opa_d  [S];
   logic [WIDTH-1:0] opb_q  [S];
   logic [WIDTH-1:0] opb_d  [S];
   logic [WIDTH-1:0] psum_q [S];
   logic [WIDTH-1:0] psum_d [S];
   logic             cry_q  [S];
   logic             cry_d  [S];

   logic             out_valid_q;
   logic             out_valid_d;
   logic [WIDTH-1:0] sum_q;
   logic [WIDTH-1:0] sum_d;
   logic             cout_q;
   logic             cout_d;

   logic [BLOCK-1:0] grp_sum_s [S];
   logic [S-1:0]     grp_cout_s;
   logic             en_s;

   assign en_s     = ~out_valid_q | out_ready;
   assign in_ready = en_s & ~rst;

   for (genvar k = 0; k < S; k++) begin : g_stage
      cla_group #(.BLOCK(BLOCK)) u_group (
         .a_i    (opa_q[k][k*BLOCK +: BLOCK]),
         .b_i    (opb_q[k][k*BLOCK +: BLOCK]),
         .c_i    (cry_q[k]),
         .sum_o  (grp_sum_s[k]),
         .cout_o (grp_cout_s[k])
      );
   end

   // Next contents of every bank and of the output register.
   always_comb begin
      vld_d[0]  = in_valid;
      opa_d[0]  = a;
      psum_d[0] = {WIDTH{1'b0}};
      case (op)
         OP_SUB: begin
            opb_d[0] = ~b;
            cry_d[0] = 1'b1;
         end
         OP_ADD: begin
            opb_d[0] = b;
            cry_d[0] = cin;
         end
         default: begin
            opb_d[0] = b;
            cry_d[0] = cin;
         end
      endcase

      for (int k = 1; k < S; k++) begin
         vld_d[k]  = vld_q[k-1];
         opa_d[k]  = opa_q[k-1];
         opb_d[k]  = opb_q[k-1];
         cry_d[k]  = grp_cout_s[k-1];
         psum_d[k] = psum_q[k-1];
         psum_d[k][(k-1)*BLOCK +: BLOCK] = grp_sum_s[k-1];
      end

      out_valid_d = vld_q[S-1];
      sum_d       = psum_q[S-1];
      sum_d[(S-1)*BLOCK +: BLOCK] = grp_sum_s[S-1];
      cout_d      = grp_cout_s[S-1];
   end

   // Pipeline banks and output register; everything freezes while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < S; k++) begin
            vld_q[k]  <= 1'b0;
            opa_q[k]  <= {WIDTH{1'b0}};
            opb_q[k]  <= {WIDTH{1'b0}};
            psum_q[k] <= {WIDTH{1'b0}};
            cry_q[k]  <= 1'b0;
         end
         out_valid_q <= 1'b0;
         sum_q       <= {WIDTH{1'b0}};
         cout_q      <= 1'b0;
      end else if (en_s) begin
         for (int k = 0; k < S; k++) begin
            vld_q[k]  <= vld_d[k];
            opa_q[k]  <= opa_d[k];
            opb_q[k]  <= opb_d[k];
            psum_q[k] <= psum_d[k];
            cry_q[k]  <= cry_d[k];
         end
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;

`ifdef CLA_OVERFLOW_EN
   logic ovf_q;
   logic ovf_d;

   // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
   always_comb begin
      ovf_d = opa_q[S-1][WIDTH-1] ^ opb_q[S-1][WIDTH-1]
            ^ grp_sum_s[S-1][BLOCK-1] ^ grp_cout_s[S-1];
   end

   // Overflow flag registered alongside sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (en_s) begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Self-checking bench for pipe_cla_adder (WIDTH=32, BLOCK=8): directed table,
// random streams with stalls/bubbles, and a mid-flight reset.
`timescale 1ns/1ps
module tb_pipe_cla_adder;
   import cla_pkg::*;

   localparam int WIDTH = 32;
   localparam int BLOCK = 8;
   localparam int S     = WIDTH / BLOCK;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
      int          acc_cyc;
      bit          lat_chk;
   } exp_t;

   typedef struct {
      op_t         op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;
   op_t         op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] sum;
   logic        cout;
`ifdef CLA_OVERFLOW_EN
   logic        ovf;
`endif

   exp_t exp_q[$];
   exp_t drv_exp;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;
   bit   chk_lat;
   bit   drv_done;
   vec_t vt[12];

   pipe_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
`ifdef CLA_OVERFLOW_EN
      .ovf       (ovf),
`endif
      .cout      (cout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Reference: true integer add/subtract; cout is carry (ADD) or no-borrow (SUB).
   function automatic exp_t model(input op_t o, input logic [31:0] x, input logic [31:0] y,
                                  input logic ci);
      exp_t   e;
      longint ua, ub, ur, sa, sb, sr;
      ua = longint'(x);
      ub = longint'(y);
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      if (o == OP_SUB) begin
         ur     = ua - ub;
         e.cout = (ua >= ub);
         sr     = sa - sb;
      end else begin
         ur     = ua + ub + longint'(ci);
         e.cout = (ur >= 64'sh1_0000_0000);
         sr     = sa + sb + longint'(ci);
      end
      e.sum     = ur[31:0];
      e.ovf     = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      e.acc_cyc = 0;
      e.lat_chk = 1'b0;
      return e;
   endfunction

   function automatic vec_t mk(input op_t o, input logic [31:0] x, input logic [31:0] y,
                               input logic ci, input logic [31:0] s, input logic co,
                               input logic ov);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.cin = ci; v.sum = s; v.cout = co; v.ovf = ov;
      return v;
   endfunction

   // Scoreboard: record accepted beats, compare each consumed result in order.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got sum 0x%08h, required no result", sum);
            end else begin
               e = exp_q.pop_front();
               check("sum", {32'h0, sum}, {32'h0, e.sum});
               check("cout", {63'h0, cout}, {63'h0, e.cout});
`ifdef CLA_OVERFLOW_EN
               check("ovf", {63'h0, ovf}, {63'h0, e.ovf});
`endif
               if (e.lat_chk) check("latency", 64'(cyc - e.acc_cyc), 64'(S));
            end
         end
         if (in_valid && in_ready) begin
            e         = drv_exp;
            e.acc_cyc = cyc + 1;
            e.lat_chk = chk_lat;
            exp_q.push_back(e);
         end
      end
   end

   task automatic send(input op_t o, input logic [31:0] x, input logic [31:0] y,
                       input logic ci, input exp_t e);
      int tries = 0;
      bit acc   = 1'b0;
      op = o; a = x; b = y; cin = ci; drv_exp = e; in_valid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         tries++;
         if (!acc && tries > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: got no acceptance in %0d cycles, required acceptance", tries);
            acc = 1'b1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [31:0] x, y;
      logic        ci;
      op_t         o;
      x  = $urandom;
      y  = ($urandom_range(0, 3) == 0) ? ~x : $urandom;
      ci = 1'($urandom_range(0, 1));
      o  = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
      send(o, x, y, ci, model(o, x, y, ci));
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0 || out_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin : main
      exp_t        e;
      logic [31:0] held_sum;
      logic        held_cout;
      int          stale;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
      a = 32'h0; b = 32'h0; cin = 1'b0; chk_lat = 1'b1; drv_done = 1'b0;
      drv_exp = model(OP_ADD, 32'h0, 32'h0, 1'b0);

      vt[0]  = mk(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      vt[1]  = mk(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
      vt[2]  = mk(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0001, 1'b0, 1'b1);
      vt[3]  = mk(OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0);
      vt[4]  = mk(OP_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      vt[5]  = mk(OP_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      vt[6]  = mk(OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
      vt[7]  = mk(OP_ADD, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0);
      vt[8]  = mk(OP_SUB, 32'h0000_0010, 32'h0000_0003, 1'b0, 32'h0000_000D, 1'b1, 1'b0);
      vt[9]  = mk(OP_SUB, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_000D, 1'b1, 1'b0);
      vt[10] = mk(OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
      vt[11] = mk(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h2345_678A, 1'b0, 1'b0);

      // Reset state, with a beat offered that must not be taken.
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b1;
      #1;
      check("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("rst_in_ready", {63'h0, in_ready}, 64'h0);
      check("rst_sum", {32'h0, sum}, 64'h0);
      check("rst_cout", {63'h0, cout}, 64'h0);
      in_valid = 1'b0;
      rst      = 1'b0;

      // Directed table, one isolated beat at a time with exact latency.
      foreach (vt[i]) begin
         e.sum = vt[i].sum; e.cout = vt[i].cout; e.ovf = vt[i].ovf;
         e.acc_cyc = 0; e.lat_chk = 1'b0;
         send(vt[i].op, vt[i].a, vt[i].b, vt[i].cin, e);
         wait_drain(20);
      end

      // Sixteen back-to-back random beats; fixed latency implies consecutive results.
      for (int i = 0; i < 16; i++) send_rand();
      wait_drain(30);

      // Three-cycle stall while results are pending.
      chk_lat = 1'b0;
      fork
         begin
            for (int i = 0; i < 10; i++) send_rand();
         end
         begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 20) begin
               @(negedge clk);
               n++;
            end
            check("stall_setup_out_valid", {63'h0, out_valid}, 64'h1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            held_sum  = sum;
            held_cout = cout;
            repeat (3) begin
               @(negedge clk);
               check("stall_in_ready", {63'h0, in_ready}, 64'h0);
               check("stall_out_valid", {63'h0, out_valid}, 64'h1);
               check("stall_sum", {32'h0, sum}, {32'h0, held_sum});
               check("stall_cout", {63'h0, cout}, {63'h0, held_cout});
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_drain(40);

      // Random bubbles and back-pressure.
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send_rand();
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      wait_drain(60);

      // Reset with beats in flight: outputs clear at once, nothing stale after.
      chk_lat = 1'b1;
      for (int i = 0; i < 5; i++) send_rand();
      check("pre_rst_out_valid", {63'h0, out_valid}, 64'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
      check("mid_rst_sum", {32'h0, sum}, 64'h0);
      check("mid_rst_cout", {63'h0, cout}, 64'h0);
      check("mid_rst_in_ready", {63'h0, in_ready}, 64'h0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst   = 1'b0;
      stale = 0;
      repeat (10) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("post_rst_stale", 64'(stale), 64'h0);

      // Recovery after reset.
      e.sum = vt[2].sum; e.cout = vt[2].cout; e.ovf = vt[2].ovf;
      e.acc_cyc = 0; e.lat_chk = 1'b0;
      send(vt[2].op, vt[2].a, vt[2].b, vt[2].cin, e);
      wait_drain(20);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
